// File: rtl/clock_pulse_gen.sv
// Programmable square-wave generator with continuous or fixed-length burst mode,
// per-edge strobes, a completed-period counter and a done strobe.
module clock_pulse_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] half_period,
    input  logic [WIDTH-1:0] burst_len,
    input  logic             init_level,
    output logic             pulse_out,
    output logic             busy,
    output logic             edge_tick,
    output logic             done,
    output logic [WIDTH-1:0] period_count
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] hp_r, hp_s;
    logic [WIDTH-1:0] bl_r, bl_s;
    logic             mode_r, mode_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic             phase_r, phase_s;
    logic             pulse_s, busy_s, edge_s, done_s;
    logic [WIDTH-1:0] pc_s;
    logic             expiry_s, period_end_s, burst_end_s;

    // Half-period expiry; a period completes on the second toggle (phase_r set).
    always_comb begin
        expiry_s     = (cnt_r == (hp_r - ONE));
        period_end_s = expiry_s & phase_r;
        burst_end_s  = period_end_s & mode_r & (period_count == (bl_r - ONE));
    end

    // Next-state and next-output logic; stop outranks burst completion, which outranks toggle.
    always_comb begin
        state_s = state_r;
        hp_s    = hp_r;
        bl_s    = bl_r;
        mode_s  = mode_r;
        cnt_s   = cnt_r;
        phase_s = phase_r;
        pulse_s = pulse_out;
        busy_s  = busy;
        edge_s  = 1'b0;
        done_s  = 1'b0;
        pc_s    = period_count;
        case (state_r)
            IDLE: begin
                pulse_s = 1'b0;
                busy_s  = 1'b0;
                if (start) begin
                    state_s = RUN;
                    hp_s    = (half_period == ZERO) ? ONE : half_period;
                    bl_s    = (burst_len == ZERO) ? ONE : burst_len;
                    mode_s  = mode;
                    pulse_s = init_level;
                    busy_s  = 1'b1;
                    cnt_s   = ZERO;
                    phase_s = 1'b0;
                    pc_s    = ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_s = IDLE;
                    pulse_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    cnt_s   = ZERO;
                    phase_s = 1'b0;
                end else if (burst_end_s) begin
                    state_s = IDLE;
                    pulse_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    edge_s  = 1'b1;
                    cnt_s   = ZERO;
                    phase_s = 1'b0;
                    pc_s    = bl_r;
                end else if (expiry_s) begin
                    cnt_s   = ZERO;
                    pulse_s = ~pulse_out;
                    edge_s  = 1'b1;
                    phase_s = ~phase_r;
                    if (phase_r) begin
                        pc_s = period_count + ONE;
                    end else begin
                        pc_s = period_count;
                    end
                end else begin
                    cnt_s = cnt_r + ONE;
                end
            end
            default: begin
                state_s = IDLE;
                pulse_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            hp_r         <= ONE;
            bl_r         <= ONE;
            mode_r       <= 1'b0;
            cnt_r        <= ZERO;
            phase_r      <= 1'b0;
            pulse_out    <= 1'b0;
            busy         <= 1'b0;
            edge_tick    <= 1'b0;
            done         <= 1'b0;
            period_count <= ZERO;
        end else begin
            state_r      <= state_s;
            hp_r         <= hp_s;
            bl_r         <= bl_s;
            mode_r       <= mode_s;
            cnt_r        <= cnt_s;
            phase_r      <= phase_s;
            pulse_out    <= pulse_s;
            busy         <= busy_s;
            edge_tick    <= edge_s;
            done         <= done_s;
            period_count <= pc_s;
        end
    end

endmodule

// File: tb/tb_clock_pulse_gen.sv
// Scoreboard bench: stimulus pushes expected per-cycle output vectors, a negedge
// monitor pops and compares them against the 16-bit and 4-bit instances.
module tb_clock_pulse_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, mode = 1'b0, init_level = 1'b0;
    logic [15:0] half_period = 16'd0, burst_len = 16'd0;
    logic        pulse_out, busy, edge_tick, done;
    logic [15:0] period_count;

    logic        start4 = 1'b0, stop4 = 1'b0, mode4 = 1'b0, init4 = 1'b0;
    logic [3:0]  hp4 = 4'd0, bl4 = 4'd0;
    logic        pulse4, busy4, edge4, done4;
    logic [3:0]  pc4;

    always #5 clk = ~clk;

    clock_pulse_gen #(.WIDTH(16)) dut (
        .clock(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .half_period(half_period), .burst_len(burst_len), .init_level(init_level),
        .pulse_out(pulse_out), .busy(busy), .edge_tick(edge_tick), .done(done),
        .period_count(period_count)
    );

    clock_pulse_gen #(.WIDTH(4)) dut4 (
        .clock(clk), .reset(reset), .start(start4), .stop(stop4), .mode(mode4),
        .half_period(hp4), .burst_len(bl4), .init_level(init4),
        .pulse_out(pulse4), .busy(busy4), .edge_tick(edge4), .done(done4),
        .period_count(pc4)
    );

    typedef struct packed {
        logic        sel;
        logic        p;
        logic        b;
        logic        e;
        logic        d;
        logic [15:0] pc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;

    // Monitor: one expected vector per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.sel) a = '{1'b1, pulse4, busy4, edge4, done4, {12'd0, pc4}};
            else       a = '{1'b0, pulse_out, busy, edge_tick, done, period_count};
            checks++;
            if (a === e) passed++;
            else $display("FAIL %s: got p=%b b=%b e=%b d=%b pc=%0d, expected p=%b b=%b e=%b d=%b pc=%0d",
                          nm, a.p, a.b, a.e, a.d, a.pc, e.p, e.b, e.e, e.d, e.pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Closed-form expectation for cycle j after the accepting start edge.
    function automatic exp_t model(input logic sel, input int j, input int hp, input int bl,
                                   input logic md, input logic init, input int mask);
        exp_t r;
        int   h;
        int   b;
        h = (hp == 0) ? 1 : hp;
        b = (bl == 0) ? 1 : bl;
        if (md && j >= 2 * h * b) begin
            r = '{sel, 1'b0, 1'b0, 1'b1, 1'b1, 16'(b)};
        end else begin
            r.sel = sel;
            r.p   = init ^ (((j / h) % 2) == 1);
            r.b   = 1'b1;
            r.e   = (j > 0) && ((j % h) == 0);
            r.d   = 1'b0;
            r.pc  = 16'((j / (2 * h)) & mask);
        end
        return r;
    endfunction

    task automatic run_seg(input string nm, input logic sel, input int n, input int hp,
                           input int bl, input logic md, input logic init, input int mask);
        if (sel) begin
            hp4 = 4'(hp); bl4 = 4'(bl); mode4 = md; init4 = init; start4 = 1'b1;
        end else begin
            half_period = 16'(hp); burst_len = 16'(bl); mode = md; init_level = init; start = 1'b1;
        end
        tick();
        push(nm, model(sel, 0, hp, bl, md, init, mask));
        start = 1'b0;
        start4 = 1'b0;
        for (int j = 1; j < n; j++) begin
            tick();
            push(nm, model(sel, j, hp, bl, md, init, mask));
        end
    endtask

    initial begin
        reset = 1'b1;
        tick();
        push("reset_main", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        tick();
        push("reset_w4", '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        reset = 1'b0;

        // Continuous hp=20, period_count reaches 150 at cycle 6000, then stop.
        run_seg("cont_hp20", 1'b0, 6001, 20, 0, 1'b0, 1'b1, 16'hFFFF);
        stop = 1'b1;
        tick();
        push("cont_stop", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd150});
        stop = 1'b0;
        tick();
        push("cont_idle", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd150});

        // Burst hp=3 bl=2 init=0.
        run_seg("burst_3x2", 1'b0, 13, 3, 2, 1'b1, 1'b0, 16'hFFFF);
        tick();
        push("burst_idle", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2});

        // Zero hp/bl behave as one.
        run_seg("burst_zero", 1'b0, 3, 0, 0, 1'b1, 1'b1, 16'hFFFF);
        tick();
        push("zero_idle", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1});

        // Continuous hp=5 with ignored mid-run start, then stop+start at cycle 13.
        half_period = 16'd5; mode = 1'b0; init_level = 1'b0; start = 1'b1;
        tick();
        push("hp5", model(1'b0, 0, 5, 0, 1'b0, 1'b0, 16'hFFFF));
        start = 1'b0;
        for (int j = 1; j < 13; j++) begin
            if (j == 4) begin start = 1'b1; half_period = 16'd7; end
            tick();
            push("hp5_ignore_start", model(1'b0, j, 5, 0, 1'b0, 1'b0, 16'hFFFF));
            start = 1'b0;
        end
        stop = 1'b1; start = 1'b1; half_period = 16'd2;
        tick();
        push("stop_with_start", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1});
        tick();
        push("start_over_stop", model(1'b0, 0, 2, 0, 1'b0, 1'b0, 16'hFFFF));
        start = 1'b0; stop = 1'b0;
        for (int j = 1; j < 9; j++) begin
            tick();
            push("hp2", model(1'b0, j, 2, 0, 1'b0, 1'b0, 16'hFFFF));
        end
        stop = 1'b1;
        tick();
        push("hp2_stop", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2});
        stop = 1'b0;

        // Reset mid-burst, then a clean burst.
        half_period = 16'd4; burst_len = 16'd3; mode = 1'b1; init_level = 1'b1; start = 1'b1;
        tick();
        push("pre_reset", model(1'b0, 0, 4, 3, 1'b1, 1'b1, 16'hFFFF));
        start = 1'b0;
        for (int j = 1; j < 7; j++) begin
            tick();
            push("pre_reset", model(1'b0, j, 4, 3, 1'b1, 1'b1, 16'hFFFF));
        end
        reset = 1'b1;
        tick();
        push("mid_reset", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        reset = 1'b0;
        tick();
        push("post_reset_idle", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        run_seg("burst_4x3", 1'b0, 25, 4, 3, 1'b1, 1'b1, 16'hFFFF);
        tick();
        push("burst_4x3_idle", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3});

        // WIDTH=4 instance: hp=1 continuous, period_count wraps.
        run_seg("w4_wrap", 1'b1, 41, 1, 0, 1'b0, 1'b0, 15);
        stop4 = 1'b1;
        tick();
        push("w4_stop", '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4});
        stop4 = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
